knap_search_ctrl: RTL and testbench
===================================

Name: knap_search_ctrl

Overview:
- Sequential search engine over knapsack selection vectors.
- Enumerates candidate vectors in a programmed range and evaluates each on one shared serial accumulator, one item per cycle.
- Applies the team's knapsack validity rule (value >= min, weight <= max, volume <= max) to each candidate.
- Streams valid solutions out over a valid/ready port, and reports the valid count and the best-value solution.
- Sits between the host config bus and downstream solution consumers; replaces N_ITEMS-wide combinational checkers where area matters.

Parameters:
N_ITEMS, 19, number of items; candidate vector width; bit i = item i (bit0 = item A)
COEF_W, 8, width of each per-item value/weight/volume coefficient
ACC_W, 9, width of accumulators and limits; all sums modulo 2^ACC_W
CNT_W, 20, width of valid-solution counter
MIN_VALUE_RST, 120, reset value of min_value limit
MAX_WEIGHT_RST, 60, reset value of max_weight limit
MAX_VOLUME_RST, 60, reset value of max_volume limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_sel  in  2  0=value table, 1=weight table, 2=volume table, 3=limits
cfg_addr  in  5  item index (tables); limits: 0=min_value, 1=max_weight, 2=max_volume
cfg_data  in  ACC_W  write data; tables take low COEF_W bits
start  in  1  begin search (accepted only when idle)
cand_first  in  N_ITEMS  first candidate, sampled on accepted start
cand_last  in  N_ITEMS  last candidate inclusive, sampled on accepted start
busy  out  1  search in progress
done  out  1  one-cycle pulse at search end
sol_valid  out  1  valid solution presented
sol_ready  in  1  consumer accepts solution
sol_vec  out  N_ITEMS  solution selection vector
sol_value  out  ACC_W  solution total value
valid_count  out  CNT_W  valid candidates found; saturates at all-ones
best_found  out  1  at least one valid candidate found
best_vec  out  N_ITEMS  first candidate achieving the max value
best_value  out  ACC_W  max valid value

Behaviour:
- Reset values:
  - all outputs 0; limits = *_RST parameters; coefficient tables 0; FSM in IDLE.
  - Reset mid-search aborts immediately with no done pulse.
- Config:
  - cfg_we is honoured only in IDLE; writes while busy are dropped.
  - cfg_addr >= N_ITEMS (tables) or > 2 (limits) is ignored.
- FSM states: IDLE, EVAL, CHECK, EMIT, DONE.
- IDLE:
  - start=1 latches the range, clears valid_count/best_*, sets cur = cand_first, clears accumulators.
  - Goes to EVAL if cand_first <= cand_last, else DONE.
  - busy=1 from the next cycle.
- EVAL:
  - Runs exactly N_ITEMS cycles, item index k = 0..N_ITEMS-1.
  - Each cycle, if cur[k]=1, adds value/weight/volume coef[k], zero-extended, into the three ACC_W accumulators, modulo 2^ACC_W (bit-exact with the combinational checker).
  - Then goes to CHECK.
- CHECK (1 cycle):
  - valid = (val >= min_value) && (wt <= max_weight) && (vol <= max_volume).
  - If valid: increment valid_count (saturating). If not best_found, or val > best_value, update best_* (ties keep the earlier vector). Then go to EMIT.
  - If invalid: advance.
- EMIT:
  - sol_valid=1 with sol_vec=cur, sol_value=val, held stable until sol_ready; transfer on sol_valid && sol_ready, then advance.
  - Minimum 1 cycle; sol_ready high in the CHECK cycle has no effect.
- Advance:
  - If cur == cand_last, go to DONE (no increment, so cand_last = all-ones never wraps).
  - Else cur += 1, clear accumulators, go to EVAL.
- DONE (1 cycle): done=1, busy=0; return to IDLE.
- Results (valid_count, best_*) hold until the next accepted start.
- start while busy is ignored. start in the DONE cycle is ignored.
- Latency with sol_ready tied 1: start accepted in cycle 0 -> done in cycle 1 + K*(N_ITEMS+1) + V.
  - K = number of candidates, V = number of valid candidates.
  - Empty range: done in cycle 1.

Decomposition:
- Package knap_pkg:
  - FSM state enum
  - cfg_sel encodings
  - limit address constants
  - default limit constants (120/60/60)
- Sub-module knap_item_acc:
  - three ACC_W serial accumulators with clear/enable/add-coef inputs
  - combinational valid compare against the limits
- Controller instantiates one knap_item_acc and owns the tables, FSM, counters and output stream.

Test Plan:
- Reset defaults; program coefs val={4,8,0,20,10,12,18,14,6,15,30,8,16,18,18,14,7,7,29}, wt={28,8,27,18,27,28,6,1,20,0,5,13,8,14,22,12,23,26,1}, vol={27,27,4,4,0,24,4,20,12,15,5,2,9,28,19,18,30,12,28}; range 0x01EC8..0x01EC8 -> sol_vec=0x01EC8, sol_value=121, valid_count=1, best_value=121, done at cycle 22.
- Same tables, range 0x01E48..0x01E48 (val 107) -> no sol_valid, valid_count=0, best_found=0, done at cycle 21.
- Range 0x01EC8..0x01EC9 with sol_ready held 0 for 5 cycles -> sol_valid stable 5 cycles, then one transfer; valid_count=1; done delayed by 5 cycles.
- cand_first=0x00005 > cand_last=0x00003 -> done pulse at cycle 1, valid_count=0, no sol_valid.
- Wrap: weight coef A=B=C=255, min_value=0, max_weight=260, others 0; candidate 0x00007 -> weight 765 mod 512 = 253, valid, valid_count=1.
- cfg write while busy, and start while busy, both ignored; assert rst_n=0 mid-EVAL -> busy=0, sol_valid=0, no done, tables cleared, limits 120/60/60.

Source files
------------

// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack search controller.
//   state_t        : controller FSM states
//   SEL_*          : cfg_sel encodings (coefficient tables / limit registers)
//   LIM_*          : cfg_addr values selecting a limit register when cfg_sel = SEL_LIMIT
//   DEF_*          : reset values of the three limit registers
package knap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EVAL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_VALUE  = 2'd0;
    localparam logic [1:0] SEL_WEIGHT = 2'd1;
    localparam logic [1:0] SEL_VOLUME = 2'd2;
    localparam logic [1:0] SEL_LIMIT  = 2'd3;

    localparam logic [4:0] LIM_MIN_VALUE  = 5'd0;
    localparam logic [4:0] LIM_MAX_WEIGHT = 5'd1;
    localparam logic [4:0] LIM_MAX_VOLUME = 5'd2;

    localparam int DEF_MIN_VALUE  = 120;
    localparam int DEF_MAX_WEIGHT = 60;
    localparam int DEF_MAX_VOLUME = 60;

endpackage

// File: rtl/knap_item_acc.sv
// Serial value/weight/volume accumulator shared by every candidate.
// One item's coefficients are added per enabled cycle; all sums wrap
// modulo 2^ACC_W so the result is bit-exact with a wide combinational
// adder tree of the same width.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : zero all three accumulators (wins over enable)
//   enable               : add the presented coefficients this cycle
//   add_value/weight/volume : per-item coefficients, zero-extended on add
//   min_value, max_weight, max_volume : validity limits
//   value_sum            : current value accumulator
//   is_valid             : validity of the current sums against the limits
module knap_item_acc
    import knap_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int ACC_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [COEF_W-1:0] add_value,
    input  logic [COEF_W-1:0] add_weight,
    input  logic [COEF_W-1:0] add_volume,
    input  logic [ACC_W-1:0]  min_value,
    input  logic [ACC_W-1:0]  max_weight,
    input  logic [ACC_W-1:0]  max_volume,
    output logic [ACC_W-1:0]  value_sum,
    output logic              is_valid
);

    logic [ACC_W-1:0] weight_sum;
    logic [ACC_W-1:0] volume_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_sum  <= '0;
            weight_sum <= '0;
            volume_sum <= '0;
        end else if (clear) begin
            value_sum  <= '0;
            weight_sum <= '0;
            volume_sum <= '0;
        end else if (enable) begin
            value_sum  <= value_sum  + ACC_W'(add_value);
            weight_sum <= weight_sum + ACC_W'(add_weight);
            volume_sum <= volume_sum + ACC_W'(add_volume);
        end
    end

    assign is_valid = (value_sum >= min_value) &&
                      (weight_sum <= max_weight) &&
                      (volume_sum <= max_volume);

endmodule

// File: rtl/knap_search_ctrl.sv
// Sequential knapsack search engine. Walks every candidate selection
// vector from cand_first to cand_last (inclusive), evaluates it one item
// per cycle on a shared accumulator, streams valid candidates out and
// tracks the valid count and the best-value candidate.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_we/sel/addr/data  : config write port (tables and limits), idle only
//   start, cand_first, cand_last : search request, accepted only in IDLE
//   busy, done            : search in progress / one-cycle completion pulse
//   sol_valid, sol_ready, sol_vec, sol_value : solution stream
//     (a solution transfers on a cycle where sol_valid && sol_ready; while
//      sol_valid is high and sol_ready low, sol_vec/sol_value hold stable)
//   valid_count, best_found, best_vec, best_value : result registers
module knap_search_ctrl
    import knap_pkg::*;
#(
    parameter int N_ITEMS        = 19,
    parameter int COEF_W         = 8,
    parameter int ACC_W          = 9,
    parameter int CNT_W          = 20,
    parameter int MIN_VALUE_RST  = DEF_MIN_VALUE,
    parameter int MAX_WEIGHT_RST = DEF_MAX_WEIGHT,
    parameter int MAX_VOLUME_RST = DEF_MAX_VOLUME
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [4:0]         cfg_addr,
    input  logic [ACC_W-1:0]   cfg_data,
    input  logic               start,
    input  logic [N_ITEMS-1:0] cand_first,
    input  logic [N_ITEMS-1:0] cand_last,
    output logic               busy,
    output logic               done,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_vec,
    output logic [ACC_W-1:0]   sol_value,
    output logic [CNT_W-1:0]   valid_count,
    output logic               best_found,
    output logic [N_ITEMS-1:0] best_vec,
    output logic [ACC_W-1:0]   best_value
);

    localparam int K_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_ITEMS - 1);

    state_t state;
    state_t state_nxt;

    logic [N_ITEMS-1:0] cur;
    logic [N_ITEMS-1:0] last;
    logic [K_W-1:0]     k;

    logic [COEF_W-1:0] value_tab  [N_ITEMS];
    logic [COEF_W-1:0] weight_tab [N_ITEMS];
    logic [COEF_W-1:0] volume_tab [N_ITEMS];

    logic [ACC_W-1:0] min_value;
    logic [ACC_W-1:0] max_weight;
    logic [ACC_W-1:0] max_volume;

    logic             start_take;
    logic             advance;
    logic             acc_clear;
    logic             acc_en;
    logic             is_valid;
    logic [ACC_W-1:0] value_sum;
    logic             at_last;

    assign at_last = (cur == last);

    // ---------------- accumulator ----------------
    knap_item_acc #(
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (acc_clear),
        .enable     (acc_en),
        .add_value  (value_tab[k]),
        .add_weight (weight_tab[k]),
        .add_volume (volume_tab[k]),
        .min_value  (min_value),
        .max_weight (max_weight),
        .max_volume (max_volume),
        .value_sum  (value_sum),
        .is_valid   (is_valid)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_take = 1'b0;
        advance    = 1'b0;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    acc_clear  = 1'b1;
                    state_nxt  = (cand_first <= cand_last) ? ST_EVAL : ST_DONE;
                end
            end
            ST_EVAL: begin
                acc_en = cur[k];
                if (k == K_LAST) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_valid) begin
                    state_nxt = ST_EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_EMIT: begin
                if (sol_ready) begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Stopping on cur == last (instead of incrementing past it) keeps
        // a range ending at all-ones from wrapping back to zero.
        if (advance) begin
            if (at_last) begin
                state_nxt = ST_DONE;
            end else begin
                state_nxt = ST_EVAL;
                acc_clear = 1'b1;
            end
        end
    end

    // ---------------- candidate walk and results ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= '0;
            last        <= '0;
            k           <= '0;
            valid_count <= '0;
            best_found  <= 1'b0;
            best_vec    <= '0;
            best_value  <= '0;
        end else begin
            if (start_take) begin
                cur         <= cand_first;
                last        <= cand_last;
                k           <= '0;
                valid_count <= '0;
                best_found  <= 1'b0;
                best_vec    <= '0;
                best_value  <= '0;
            end

            if (state == ST_EVAL) begin
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            end

            if ((state == ST_CHECK) && is_valid) begin
                if (valid_count != '1) begin
                    valid_count <= valid_count + 1'b1;
                end
                // Strict compare: a tie keeps the earlier candidate.
                if (!best_found || (value_sum > best_value)) begin
                    best_found <= 1'b1;
                    best_vec   <= cur;
                    best_value <= value_sum;
                end
            end

            if (advance && !at_last) begin
                cur <= cur + 1'b1;
                k   <= '0;
            end
        end
    end

    // ---------------- configuration ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                value_tab[i]  <= '0;
                weight_tab[i] <= '0;
                volume_tab[i] <= '0;
            end
            min_value  <= ACC_W'(MIN_VALUE_RST);
            max_weight <= ACC_W'(MAX_WEIGHT_RST);
            max_volume <= ACC_W'(MAX_VOLUME_RST);
        end else if (cfg_we && (state == ST_IDLE)) begin
            if (cfg_sel == SEL_LIMIT) begin
                case (cfg_addr)
                    LIM_MIN_VALUE:  min_value  <= cfg_data;
                    LIM_MAX_WEIGHT: max_weight <= cfg_data;
                    LIM_MAX_VOLUME: max_volume <= cfg_data;
                    default: ;
                endcase
            end else if (int'(cfg_addr) < N_ITEMS) begin
                case (cfg_sel)
                    SEL_VALUE:  value_tab[cfg_addr[K_W-1:0]]  <= cfg_data[COEF_W-1:0];
                    SEL_WEIGHT: weight_tab[cfg_addr[K_W-1:0]] <= cfg_data[COEF_W-1:0];
                    SEL_VOLUME: volume_tab[cfg_addr[K_W-1:0]] <= cfg_data[COEF_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy      = (state == ST_EVAL) || (state == ST_CHECK) || (state == ST_EMIT);
    assign done      = (state == ST_DONE);
    assign sol_valid = (state == ST_EMIT);
    assign sol_vec   = sol_valid ? cur : '0;
    assign sol_value = sol_valid ? value_sum : '0;

endmodule

// File: tb/tb_knap_search_ctrl.sv
`timescale 1ns/1ps
module tb_knap_search_ctrl;

    localparam int N      = 19;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 9;
    localparam int CNT_W  = 20;
    localparam int MOD    = 512;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_sel = '0;
    logic [4:0]       cfg_addr = '0;
    logic [ACC_W-1:0] cfg_data = '0;
    logic             start = 1'b0;
    logic [N-1:0]     cand_first = '0;
    logic [N-1:0]     cand_last = '0;
    logic             busy;
    logic             done;
    logic             sol_valid;
    logic             sol_ready = 1'b0;
    logic [N-1:0]     sol_vec;
    logic [ACC_W-1:0] sol_value;
    logic [CNT_W-1:0] valid_count;
    logic             best_found;
    logic [N-1:0]     best_vec;
    logic [ACC_W-1:0] best_value;

    always #5 clk = ~clk;

    knap_search_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .cand_first  (cand_first),
        .cand_last   (cand_last),
        .busy        (busy),
        .done        (done),
        .sol_valid   (sol_valid),
        .sol_ready   (sol_ready),
        .sol_vec     (sol_vec),
        .sol_value   (sol_value),
        .valid_count (valid_count),
        .best_found  (best_found),
        .best_vec    (best_vec),
        .best_value  (best_value)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int m_val [N];
    int m_wt  [N];
    int m_vol [N];
    int m_min, m_maxw, m_maxv;

    logic [N-1:0] exp_q [$];
    int           exp_vals [$];

    int tv [N] = '{4,8,0,20,10,12,18,14,6,15,30,8,16,18,18,14,7,7,29};
    int tw [N] = '{28,8,27,18,27,28,6,1,20,0,5,13,8,14,22,12,23,26,1};
    int tu [N] = '{27,27,4,4,0,24,4,20,12,15,5,2,9,28,19,18,30,12,28};

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0;
            m_wt[i]  = 0;
            m_vol[i] = 0;
        end
        m_min  = 120;
        m_maxw = 60;
        m_maxv = 60;
    endfunction

    function automatic int model_sum(input logic [N-1:0] c, input int which);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) s += (which == 0) ? m_val[i] : (which == 1) ? m_wt[i] : m_vol[i];
        end
        return s % MOD;
    endfunction

    function automatic bit model_valid(input logic [N-1:0] c);
        return (model_sum(c, 0) >= m_min) && (model_sum(c, 1) <= m_maxw) &&
               (model_sum(c, 2) <= m_maxv);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int sel, input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel[1:0];
        cfg_addr = addr[4:0];
        cfg_data = data[ACC_W-1:0];
        @(negedge clk);
        cfg_we = 1'b0;
        if (sel == 3) begin
            if (addr == 0)      m_min  = data % MOD;
            else if (addr == 1) m_maxw = data % MOD;
            else if (addr == 2) m_maxv = data % MOD;
        end else if (addr < N) begin
            if (sel == 0)      m_val[addr] = data % 256;
            else if (sel == 1) m_wt[addr]  = data % 256;
            else               m_vol[addr] = data % 256;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic program_test_tables();
        for (int i = 0; i < N; i++) begin
            cfg_write(0, i, tv[i]);
            cfg_write(1, i, tw[i]);
            cfg_write(2, i, tu[i]);
        end
    endtask

    // Runs one search and scores the stream and results against the model.
    // mode: 0 = sol_ready always 1, 1 = random, 2 = held 0 for 'stall' cycles per solution.
    // inject: drive a config write and a start in mid-search and a start in the done cycle.
    task automatic run_search(input logic [N-1:0] first, input logic [N-1:0] last,
                              input int mode, input int stall, input bit check_cycle,
                              input bit inject, output int max_hold);
        logic [N-1:0] c;
        logic [N-1:0] prev_vec;
        logic [ACC_W-1:0] prev_val;
        logic [N-1:0] exp_bv;
        bit more, prev_pending, seen_done, exp_bf;
        int k_cnt, v_cnt, exp_bval, exp_done, cyc, hold;

        exp_q.delete();
        exp_vals.delete();
        k_cnt = 0; v_cnt = 0; exp_bf = 0; exp_bv = '0; exp_bval = 0;
        if (first <= last) begin
            c = first;
            more = 1;
            while (more) begin
                k_cnt++;
                if (model_valid(c)) begin
                    v_cnt++;
                    exp_q.push_back(c);
                    exp_vals.push_back(model_sum(c, 0));
                    if (!exp_bf || model_sum(c, 0) > exp_bval) begin
                        exp_bf = 1; exp_bv = c; exp_bval = model_sum(c, 0);
                    end
                end
                if (c == last) more = 0;
                else c = c + 1'b1;
            end
        end
        exp_done = 1 + k_cnt * (N + 1) + v_cnt + ((mode == 2) ? v_cnt * stall : 0);

        @(negedge clk);
        start = 1'b1; cand_first = first; cand_last = last; sol_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; hold = 0; max_hold = 0; prev_pending = 0; seen_done = 0;
        prev_vec = '0; prev_val = '0;
        while (!seen_done && cyc < 6000) begin
            if (inject && cyc == 3) begin
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 5'd3; cfg_data = '0;
                start = 1'b1; cand_first = '0; cand_last = '1;
            end else if (inject && cyc == 4) begin
                cfg_we = 1'b0; start = 1'b0;
            end
            case (mode)
                0: sol_ready = 1'b1;
                1: sol_ready = ($urandom_range(0, 1) == 1);
                default: sol_ready = (sol_valid && hold < stall) ? 1'b0 : 1'b1;
            endcase
            if (sol_valid) begin
                if (prev_pending) begin
                    n_tests++;
                    if (sol_vec !== prev_vec || sol_value !== prev_val) begin
                        n_fail++;
                        $display("FAIL sol_hold: got %05h/%0d expected %05h/%0d", sol_vec, sol_value, prev_vec, prev_val);
                    end
                end
                if (sol_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sol_unexpected: got %05h/%0d expected no solution", sol_vec, sol_value);
                    end else begin
                        if (sol_vec !== exp_q[0] || sol_value !== ACC_W'(exp_vals[0])) begin
                            n_fail++;
                            $display("FAIL sol_data: got %05h/%0d expected %05h/%0d", sol_vec, sol_value, exp_q[0], exp_vals[0]);
                        end
                        void'(exp_q.pop_front());
                        void'(exp_vals.pop_front());
                    end
                    prev_pending = 0;
                    hold = 0;
                end else begin
                    prev_pending = 1; prev_vec = sol_vec; prev_val = sol_value;
                    hold++;
                    if (hold > max_hold) max_hold = hold;
                end
            end
            if (done) begin
                seen_done = 1;
                if (check_cycle) begin
                    n_tests++;
                    if (cyc != exp_done) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d expected %0d", cyc, exp_done);
                    end
                end
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_in_done: got %0b expected 0", busy);
                end
            end else begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_during_search: got %0b expected 1 at cycle %0d", busy, cyc);
                end
                @(negedge clk);
                cyc++;
            end
        end
        n_tests++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected %0d", cyc, exp_done);
        end
        if (inject) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sol_ready = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: got done=%0b busy=%0b expected 0/0", done, busy);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sol_missing: got %0d outstanding expected 0", exp_q.size());
        end
        n_tests++;
        if (valid_count !== CNT_W'(v_cnt)) begin
            n_fail++;
            $display("FAIL valid_count: got %0d expected %0d", valid_count, v_cnt);
        end
        n_tests++;
        if (best_found !== exp_bf || (exp_bf && (best_vec !== exp_bv || best_value !== ACC_W'(exp_bval)))) begin
            n_fail++;
            $display("FAIL best: got %0b/%05h/%0d expected %0b/%05h/%0d", best_found, best_vec, best_value, exp_bf, exp_bv, exp_bval);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        n_tests++;
        if ({busy, done, sol_valid, best_found} !== 4'b0 || sol_vec !== '0 || sol_value !== '0 ||
            valid_count !== '0 || best_vec !== '0 || best_value !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b sv=%0b vc=%0d bf=%0b bv=%0d expected all 0",
                     busy, done, sol_valid, valid_count, best_found, best_value);
        end
    endtask

    task automatic test_single_valid();
        int mh;
        program_test_tables();
        run_search(19'h01EC8, 19'h01EC8, 0, 0, 1, 0, mh);
        n_tests++;
        if (best_value !== 9'd121 || best_vec !== 19'h01EC8 || valid_count !== 20'd1) begin
            n_fail++;
            $display("FAIL single_valid: got %0d/%05h/%0d expected 121/01ec8/1", best_value, best_vec, valid_count);
        end
    endtask

    task automatic test_single_invalid();
        int mh;
        run_search(19'h01E48, 19'h01E48, 0, 0, 1, 0, mh);
        n_tests++;
        if (best_found !== 1'b0 || valid_count !== '0) begin
            n_fail++;
            $display("FAIL single_invalid: got bf=%0b vc=%0d expected 0/0", best_found, valid_count);
        end
    endtask

    task automatic test_backpressure();
        int mh;
        run_search(19'h01EC8, 19'h01EC9, 2, 5, 1, 0, mh);
        n_tests++;
        if (mh != 5) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d stalled cycles expected 5", mh);
        end
    endtask

    task automatic test_empty_range();
        int mh;
        run_search(19'h00005, 19'h00003, 0, 0, 1, 0, mh);
    endtask

    task automatic test_busy_ignored();
        int mh;
        run_search(19'h01EC8, 19'h01EC8, 0, 0, 1, 1, mh);
    endtask

    task automatic test_top_of_range();
        int mh;
        run_search(19'h7FFFE, 19'h7FFFF, 0, 0, 1, 0, mh);
    endtask

    task automatic test_random();
        int mh;
        logic [N-1:0] f;
        logic [N-1:0] l;
        int len;
        for (int iter = 0; iter < 5; iter++) begin
            for (int i = 0; i < N; i++) begin
                cfg_write(0, i, $urandom_range(0, 40));
                cfg_write(1, i, $urandom_range(0, 30));
                cfg_write(2, i, $urandom_range(0, 30));
            end
            cfg_write(3, 0, $urandom_range(20, 140));
            cfg_write(3, 1, $urandom_range(30, 140));
            cfg_write(3, 2, $urandom_range(30, 140));
            // writes to unmapped addresses must leave everything unchanged
            cfg_write($urandom_range(0, 2), $urandom_range(19, 31), $urandom_range(0, 511));
            cfg_write(3, $urandom_range(3, 31), $urandom_range(0, 511));
            f = N'($urandom_range(0, (1 << N) - 1));
            len = $urandom_range(0, 12);
            l = (int'(f) + len > (1 << N) - 1) ? '1 : f + N'(len);
            run_search(f, l, 1, 0, 0, 0, mh);
        end
    endtask

    task automatic test_reset_mid_search();
        int mh, bad_done;
        bad_done = 0;
        @(negedge clk);
        start = 1'b1; cand_first = 19'h01EC8; cand_last = 19'h01ECF; sol_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: got %0b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || sol_valid !== 1'b0 || done !== 1'b0 || valid_count !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: got busy=%0b sv=%0b done=%0b vc=%0d expected 0/0/0/0", busy, sol_valid, done, valid_count);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) bad_done++;
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        if (done) bad_done++;
        n_tests++;
        if (bad_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done cycles expected 0", bad_done);
        end
        // only items 0/1 programmed: results depend on cleared tables and default limits
        cfg_write(0, 0, 120); cfg_write(1, 0, 60); cfg_write(2, 0, 60);
        cfg_write(0, 1, 119);
        run_search(19'h7FFFD, 19'h7FFFF, 0, 0, 1, 0, mh);
    endtask

    task automatic test_wrap();
        int mh;
        do_reset();
        cfg_write(1, 0, 255); cfg_write(1, 1, 255); cfg_write(1, 2, 255);
        cfg_write(3, 0, 0);
        cfg_write(3, 1, 260);
        run_search(19'h00007, 19'h00007, 0, 0, 1, 0, mh);
        n_tests++;
        if (valid_count !== 20'd1 || best_found !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_valid: got vc=%0d bf=%0b expected 1/1", valid_count, best_found);
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_valid();
        test_single_invalid();
        test_backpressure();
        test_empty_range();
        test_busy_ignored();
        test_top_of_range();
        test_random();
        test_reset_mid_search();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
